bin_to_bcd_seq: RTL and testbench
=================================

// Module: bin_to_bcd_seq
// PURPOSE
//   Sequential binary-to-BCD converter (shift-and-add-3 / double dabble), one input bit per clock.
//   Inverse of the calculator's BCD-to-binary processor: turns ALU binary results back into
//   packed BCD digits for the 7-segment display path. Uses the same start/done handshake.
// PARAMETERS
//   BIN_W   14   width of binary operand (unsigned)
//   DIGITS  4    number of BCD output digits; data_out width = 4*DIGITS
// PORTS
//   clk       in   1          system clock, all state on rising edge
//   reset     in   1          asynchronous, active-high; clears all state
//   start     in   1          request conversion; sampled only in IDLE
//   data_in   in   BIN_W      unsigned binary operand, sampled with start
//   data_out  out  4*DIGITS   packed BCD result, digit 0 in [3:0]
//   done      out  1          one-cycle pulse: data_out/overflow valid and updated
//   busy      out  1          high from the accepting edge until done is asserted
//   overflow  out  1          operand > 10**DIGITS-1; valid with done, held until next done
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, data_out=0, done=0, busy=0, overflow=0, shift regs=0.
//   FSM: IDLE -> SHIFT -> DONE -> IDLE.
//   - IDLE: on edge k with start=1: latch data_in into shift reg, clear BCD accumulator,
//     bit counter=BIN_W-1, compute overflow_next = (data_in > 10**DIGITS-1), busy=1 -> SHIFT.
//     start=0: stay, outputs hold.
//   - SHIFT: each cycle: per digit, if nibble >= 5 add 3 (all digits in parallel, before shift),
//     then shift {bcd,bin} left by 1. After BIN_W shifts -> DONE. Counter decrements; on 0 -> DONE.
//   - DONE (entered at edge k+BIN_W): done=1, busy=0 (same edge); data_out <= accumulator, or
//     all-9s (4'h9 per digit) if overflow_next; overflow <= overflow_next. Next edge -> IDLE, done=0.
//   Latency: done high in the cycle after edge k+BIN_W, i.e. BIN_W+1 cycles after start sampled.
//   Throughput: one conversion per BIN_W+2 cycles; start held high => back-to-back conversions,
//     next operand sampled on the edge that leaves DONE? No: sampled only in IDLE (one idle cycle).
//   start while busy (SHIFT/DONE): ignored, no queueing; data_in changes while busy have no effect.
//   data_out/overflow change only on the edge that asserts done; stable otherwise (incl. IDLE).
//   Add-3 is per 4-bit nibble, no carry between digits; accumulator width 4*DIGITS, upper bits
//     discarded on overflow (result then replaced by saturation value above).
//   Reset mid-SHIFT: conversion aborted, no done pulse, outputs to reset values; new start
//     accepted on first edge after reset deasserts.
//   done and busy are never high in the same cycle.
// TESTING
//   1. data_in=0, start 1 cycle -> done after 15 cycles, data_out=16'h0000, overflow=0.
//   2. data_in=1234 (14'h04D2) -> data_out=16'h1234, overflow=0; busy high exactly 14 cycles.
//   3. data_in=9999 -> 16'h9999, overflow=0; data_in=10000 -> 16'h9999, overflow=1;
//      data_in=16383 -> 16'h9999, overflow=1.
//   4. start=1 with data_in=5678, then pulse start=1 with data_in=42 mid-SHIFT -> single done,
//      data_out=16'h5678; second request ignored.
//   5. start held high, data_in=7 then 8 -> consecutive done pulses 16 cycles apart, 16'h0007, 16'h0008.
//   6. reset asserted 5 cycles into SHIFT (data_in=4321) -> outputs 0 immediately (async), no done;
//      after release, data_in=4321 start -> 16'h4321.
```

Note: the "Throughput" bullet contains a leftover question ("sampled on the edge that leaves DONE? No: ..."). The intended rule is the one in the IDLE bullet: start is sampled only in IDLE. That bullet could be reworded to "next operand sampled only in IDLE (one idle cycle between conversions)".

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one operand bit per clock.
// Operands above the largest representable decimal value saturate to all nines and raise overflow.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      data_in,
  output logic [4*DIGITS-1:0]   data_out,
  output logic                  done,
  output logic                  busy,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  localparam longint unsigned MAX_VAL = pow10(DIGITS) - 64'd1;
  localparam logic [BCD_W-1:0] SAT_VAL = {DIGITS{4'h9}};

  // Decimal-adjust every nibble independently; no carry crosses a digit boundary.
  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] acc);
    logic [BCD_W-1:0] r;
    r = acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) begin
        r[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end else begin
        r[4*d +: 4] = acc[4*d +: 4];
      end
    end
    return r;
  endfunction

  function automatic logic exceeds_max(input logic [BIN_W-1:0] v);
    return 64'(v) > MAX_VAL;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [BIN_W-1:0]   bin_r, bin_s;
  logic [BCD_W-1:0]   bcd_r, bcd_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               ovf_pend_r, ovf_pend_s;
  logic [BCD_W-1:0]   data_out_s;
  logic               done_s, busy_s, overflow_s;
  logic [BCD_W-1:0]   adj_s, shifted_bcd_s;
  logic [BIN_W-1:0]   shifted_bin_s;

  // State and output registers; everything clears on the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      bin_r      <= '0;
      bcd_r      <= '0;
      cnt_r      <= '0;
      ovf_pend_r <= 1'b0;
      data_out   <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state_r    <= state_s;
      bin_r      <= bin_s;
      bcd_r      <= bcd_s;
      cnt_r      <= cnt_s;
      ovf_pend_r <= ovf_pend_s;
      data_out   <= data_out_s;
      done       <= done_s;
      busy       <= busy_s;
      overflow   <= overflow_s;
    end
  end

  // Next-state and next-output logic for the IDLE -> SHIFT -> DONE sequence.
  always_comb begin
    state_s       = state_r;
    bin_s         = bin_r;
    bcd_s         = bcd_r;
    cnt_s         = cnt_r;
    ovf_pend_s    = ovf_pend_r;
    data_out_s    = data_out;
    done_s        = 1'b0;
    busy_s        = busy;
    overflow_s    = overflow;
    adj_s         = add3_digits(bcd_r);
    shifted_bcd_s = {adj_s[BCD_W-2:0], bin_r[BIN_W-1]};
    shifted_bin_s = {bin_r[BIN_W-2:0], 1'b0};

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          bin_s      = data_in;
          bcd_s      = '0;
          cnt_s      = CNT_W'(BIN_W - 1);
          ovf_pend_s = exceeds_max(data_in);
          busy_s     = 1'b1;
          state_s    = ST_SHIFT;
        end else begin
          state_s    = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        bcd_s = shifted_bcd_s;
        bin_s = shifted_bin_s;
        // The last shift lands directly in the output register on the same edge.
        if (cnt_r == '0) begin
          state_s    = ST_DONE;
          done_s     = 1'b1;
          busy_s     = 1'b0;
          data_out_s = ovf_pend_r ? SAT_VAL : shifted_bcd_s;
          overflow_s = ovf_pend_r;
        end else begin
          cnt_s      = cnt_r - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomized self-checking bench for bin_to_bcd_seq against an arithmetic decimal-digit model.
module tb_bin_to_bcd_seq;

  localparam int BIN_W  = 14;
  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] data_in;
  logic [15:0] data_out;
  logic        done;
  logic        busy;
  logic        overflow;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .data_in  (data_in),
    .data_out (data_out),
    .done     (done),
    .busy     (busy),
    .overflow (overflow)
  );

  // Decimal digits by division; saturate to 9999 above the four-digit range.
  function automatic void ref_model(input int v, output logic [15:0] bcd, output logic ovf);
    int x;
    ovf = (v > 9999);
    x   = ovf ? 9999 : v;
    bcd = 16'h0000;
    for (int d = 0; d < 4; d++) begin
      bcd[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
  endfunction

  // One conversion; reports result, latency in cycles and handshake observations.
  task automatic run_conv(input logic [13:0] v, output logic [15:0] res, output logic ovf,
                          output int lat, output int busy_cnt, output logic clash,
                          output logic unstable);
    logic [15:0] prev;
    prev = data_out; lat = -1; busy_cnt = 0; clash = 1'b0; unstable = 1'b0;
    res = 16'h0000; ovf = 1'b0;
    @(negedge clk);
    start = 1'b1; data_in = v;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      busy_cnt += int'(busy);
      if (done && busy) clash = 1'b1;
      if (done) begin
        lat = i; res = data_out; ovf = overflow;
        break;
      end else if (data_out !== prev) begin
        unstable = 1'b1;
      end
      start   = 1'b0;
      data_in = 14'($urandom);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; data_in = 14'd0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({data_out, done, busy, overflow} !== 19'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got data_out=%h done=%b busy=%b ovf=%b, expected all zero",
               data_out, done, busy, overflow);
    end
    reset = 1'b0;
  endtask

  task automatic test_zero();
    logic [15:0] res; logic ovf, clash, unst; int lat, bc;
    run_conv(14'd0, res, ovf, lat, bc, clash, unst);
    tests_run++;
    if (lat !== 15) begin tests_failed++; $display("FAIL zero_latency: got %0d expected 15", lat); end
    tests_run++;
    if (res !== 16'h0000) begin tests_failed++; $display("FAIL zero_data: got %h expected 0000", res); end
    tests_run++;
    if (ovf !== 1'b0) begin tests_failed++; $display("FAIL zero_ovf: got %b expected 0", ovf); end
  endtask

  task automatic test_known();
    logic [15:0] res; logic ovf, clash, unst; int lat, bc;
    run_conv(14'd1234, res, ovf, lat, bc, clash, unst);
    tests_run++;
    if (res !== 16'h1234) begin tests_failed++; $display("FAIL known_data: got %h expected 1234", res); end
    tests_run++;
    if (ovf !== 1'b0) begin tests_failed++; $display("FAIL known_ovf: got %b expected 0", ovf); end
    tests_run++;
    if (bc !== 14) begin tests_failed++; $display("FAIL known_busy_cycles: got %0d expected 14", bc); end
    tests_run++;
    if (clash !== 1'b0) begin tests_failed++; $display("FAIL known_done_busy_overlap: got %b expected 0", clash); end
    tests_run++;
    if (unst !== 1'b0) begin tests_failed++; $display("FAIL known_data_stable: got %b expected 0", unst); end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL known_done_pulse: got %b expected 0", done); end
    tests_run++;
    if (data_out !== 16'h1234) begin tests_failed++; $display("FAIL known_data_hold: got %h expected 1234", data_out); end
  endtask

  task automatic test_saturation();
    int vals [3] = '{9999, 10000, 16383};
    logic [15:0] res, exp_bcd; logic ovf, exp_ovf, clash, unst; int lat, bc;
    foreach (vals[j]) begin
      ref_model(vals[j], exp_bcd, exp_ovf);
      run_conv(14'(vals[j]), res, ovf, lat, bc, clash, unst);
      tests_run++;
      if (res !== exp_bcd) begin tests_failed++; $display("FAIL sat_data(%0d): got %h expected %h", vals[j], res, exp_bcd); end
      tests_run++;
      if (ovf !== exp_ovf) begin tests_failed++; $display("FAIL sat_ovf(%0d): got %b expected %b", vals[j], ovf, exp_ovf); end
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (overflow !== 1'b1) begin tests_failed++; $display("FAIL sat_ovf_hold: got %b expected 1", overflow); end
  endtask

  task automatic test_ignore_busy();
    int ndone = 0; int first = -1; logic [15:0] cap = 16'h0000;
    @(negedge clk);
    start = 1'b1; data_in = 14'd5678;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++; cap = data_out;
        if (first < 0) first = i;
      end
      if (i == 1) start = 1'b0;
      if (i == 3) begin start = 1'b1; data_in = 14'd42; end
      if (i == 4) start = 1'b0;
    end
    tests_run++;
    if (ndone !== 1) begin tests_failed++; $display("FAIL ignore_done_count: got %0d expected 1", ndone); end
    tests_run++;
    if (cap !== 16'h5678) begin tests_failed++; $display("FAIL ignore_data: got %h expected 5678", cap); end
    tests_run++;
    if (first !== 15) begin tests_failed++; $display("FAIL ignore_latency: got %0d expected 15", first); end
  endtask

  task automatic test_back_to_back();
    int ndone = 0; int idx [2] = '{-1, -1}; logic [15:0] dat [2] = '{16'h0, 16'h0};
    @(negedge clk);
    start = 1'b1; data_in = 14'd7;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        if (ndone < 2) begin idx[ndone] = i; dat[ndone] = data_out; end
        ndone++;
        if (ndone == 2) start = 1'b0;
      end
      if (i == 1) data_in = 14'd8;
    end
    start = 1'b0;
    tests_run++;
    if (ndone !== 2) begin tests_failed++; $display("FAIL b2b_done_count: got %0d expected 2", ndone); end
    tests_run++;
    if (idx[1] - idx[0] !== 16) begin tests_failed++; $display("FAIL b2b_spacing: got %0d expected 16", idx[1] - idx[0]); end
    tests_run++;
    if (dat[0] !== 16'h0007) begin tests_failed++; $display("FAIL b2b_first: got %h expected 0007", dat[0]); end
    tests_run++;
    if (dat[1] !== 16'h0008) begin tests_failed++; $display("FAIL b2b_second: got %h expected 0008", dat[1]); end
  endtask

  task automatic test_reset_mid_shift();
    logic [15:0] res; logic ovf, clash, unst; int lat, bc; int ndone = 0;
    run_conv(14'd10000, res, ovf, lat, bc, clash, unst);
    @(negedge clk);
    start = 1'b1; data_in = 14'd4321;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if ({data_out, done, busy, overflow} !== 19'd0) begin
      tests_failed++;
      $display("FAIL midreset_async: got data_out=%h done=%b busy=%b ovf=%b, expected all zero",
               data_out, done, busy, overflow);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    tests_run++;
    if (ndone !== 0) begin tests_failed++; $display("FAIL midreset_no_done: got %0d expected 0", ndone); end
    run_conv(14'd4321, res, ovf, lat, bc, clash, unst);
    tests_run++;
    if (res !== 16'h4321) begin tests_failed++; $display("FAIL midreset_restart: got %h expected 4321", res); end
    tests_run++;
    if (lat !== 15) begin tests_failed++; $display("FAIL midreset_latency: got %0d expected 15", lat); end
  endtask

  task automatic test_random();
    logic [15:0] res, exp_bcd; logic ovf, exp_ovf, clash, unst; int lat, bc, v;
    for (int it = 0; it < 24; it++) begin
      v = (it % 3 == 0) ? int'($urandom_range(9990, 10010)) : int'($urandom_range(0, 16383));
      ref_model(v, exp_bcd, exp_ovf);
      run_conv(14'(v), res, ovf, lat, bc, clash, unst);
      tests_run++;
      if (res !== exp_bcd || ovf !== exp_ovf || lat !== 15 || clash !== 1'b0) begin
        tests_failed++;
        $display("FAIL random(%0d): got data=%h ovf=%b lat=%0d clash=%b expected data=%h ovf=%b lat=15 clash=0",
                 v, res, ovf, lat, clash, exp_bcd, exp_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_known();
    test_saturation();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_shift();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
